// File: rtl/btt_pkg.sv
// Shared types and default widths for the branch target table.
package btt_pkg;

    localparam int DEF_IDX_W  = 8;
    localparam int DEF_ADDR_W = 8;

    // INIT sweeps the array clear, RUN serves reads and writes.
    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Lookup mode: absolute target or PC-relative signed offset.
    typedef enum logic {
        ABS = 1'b0,
        REL = 1'b1
    } mode_t;

endpackage

// File: rtl/btt_if.sv
// Request/response bundle between a client and the branch target table.
interface btt_if
    import btt_pkg::*;
#(
    parameter int IDX_W  = DEF_IDX_W,
    parameter int ADDR_W = DEF_ADDR_W
);

    logic              flush;
    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic [ADDR_W-1:0] wr_data;
    logic              rd_req;
    logic [IDX_W-1:0]  rd_idx;
    mode_t             rd_mode;
    logic [ADDR_W-1:0] pc;
    logic              busy;
    logic              rd_valid;
    logic              hit;
    logic [ADDR_W-1:0] target;

    modport master (
        output flush, wr_en, wr_idx, wr_data, rd_req, rd_idx, rd_mode, pc,
        input  busy, rd_valid, hit, target
    );

    modport slave (
        input  flush, wr_en, wr_idx, wr_data, rd_req, rd_idx, rd_mode, pc,
        output busy, rd_valid, hit, target
    );

endinterface

// File: rtl/btt_mem.sv
// Storage array of data plus valid bit: synchronous write, combinational read.
module btt_mem #(
    parameter int IDX_W  = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              wvalid,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid
);

    localparam int DEPTH = 1 << IDX_W;

    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DEPTH-1:0]  valid_q;

    // Array has no reset; contents become defined once the owner sweeps it.
    always_ff @(posedge clk) begin
        if (we) begin
            data_q[waddr]  <= wdata;
            valid_q[waddr] <= wvalid;
        end
    end

    assign rdata  = data_q[raddr];
    assign rvalid = valid_q[raddr];

endmodule

// File: rtl/branch_target_table.sv
// Branch target table: clear sweep after reset/flush, then 1-cycle lookups
// with write-through bypass and absolute or PC-relative target formation.
module branch_target_table
    import btt_pkg::*;
#(
    parameter int IDX_W  = DEF_IDX_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic clk,
    input  logic reset,
    btt_if.slave bus
);

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  cnt_q, cnt_d;

    logic              mem_we;
    logic [IDX_W-1:0]  mem_waddr;
    logic [ADDR_W-1:0] mem_wdata;
    logic              mem_wvalid;
    logic [ADDR_W-1:0] mem_rdata;
    logic              mem_rvalid;

    logic              wr_ok;
    logic              rd_ok;
    logic              bypass;
    logic              ent_valid;
    logic [ADDR_W-1:0] ent_data;
    logic [ADDR_W-1:0] target_d;

    logic              rd_valid_q;
    logic              hit_q;
    logic [ADDR_W-1:0] target_q;

    // State and sweep counter register; reset restarts the sweep.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: flush always restarts the sweep, INIT leaves after the last entry.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (bus.flush) begin
            state_d = INIT;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                INIT: begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == '1) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    state_d = RUN;
                end
                default: begin
                    state_d = INIT;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign wr_ok = (state_q == RUN) && bus.wr_en && !bus.flush;
    assign rd_ok = (state_q == RUN) && bus.rd_req;

    // Write port mux: the sweep owns the array in INIT, clients own it in RUN.
    always_comb begin
        mem_we     = 1'b0;
        mem_waddr  = bus.wr_idx;
        mem_wdata  = bus.wr_data;
        mem_wvalid = 1'b1;
        if (state_q == INIT) begin
            mem_we     = 1'b1;
            mem_waddr  = cnt_q;
            mem_wdata  = '0;
            mem_wvalid = 1'b0;
        end else begin
            mem_we = wr_ok;
        end
    end

    btt_mem #(
        .IDX_W  (IDX_W),
        .DATA_W (ADDR_W)
    ) u_mem (
        .clk    (clk),
        .we     (mem_we),
        .waddr  (mem_waddr),
        .wdata  (mem_wdata),
        .wvalid (mem_wvalid),
        .raddr  (bus.rd_idx),
        .rdata  (mem_rdata),
        .rvalid (mem_rvalid)
    );

    // Lookup: bypass a same-cycle write, then pick fall-through, absolute or relative target.
    always_comb begin
        bypass    = wr_ok && (bus.wr_idx == bus.rd_idx);
        ent_valid = mem_rvalid;
        ent_data  = mem_rdata;
        if (bypass) begin
            ent_valid = 1'b1;
            ent_data  = bus.wr_data;
        end
        target_d = bus.pc + ADDR_W'(1);
        if (ent_valid) begin
            if (bus.rd_mode == REL) begin
                target_d = bus.pc + ent_data;
            end else begin
                target_d = ent_data;
            end
        end
    end

    // Result register: valid pulses one cycle after an accepted read, data holds otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid_q <= 1'b0;
            hit_q      <= 1'b0;
            target_q   <= '0;
        end else begin
            rd_valid_q <= rd_ok;
            if (rd_ok) begin
                hit_q    <= ent_valid;
                target_q <= target_d;
            end
        end
    end

    assign bus.busy     = (state_q == INIT);
    assign bus.rd_valid = rd_valid_q;
    assign bus.hit      = hit_q;
    assign bus.target   = target_q;

endmodule

// File: tb/tb_branch_target_table.sv
// Directed plus short random bench for branch_target_table with a result scoreboard.
module tb_branch_target_table;
    import btt_pkg::*;

    typedef struct {
        logic       hit;
        logic [7:0] target;
        string      tag;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    btt_if #(.IDX_W(8), .ADDR_W(8)) bus ();

    branch_target_table #(
        .IDX_W  (8),
        .ADDR_W (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad   = 0;
    exp_t       sbq[$];
    logic [7:0] m_data  [256];
    logic       m_valid [256];
    logic       m_busy      = 1'b1;
    int         m_cnt       = 0;
    logic       last_hit    = 1'b0;
    logic [7:0] last_target = 8'h00;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t predict(input logic [7:0] ridx, input mode_t mode, input logic [7:0] pc_i,
                                     input logic wen, input logic [7:0] widx, input logic [7:0] wdat,
                                     input logic flush_i);
        exp_t       e;
        logic       v;
        logic [7:0] d;
        if (wen && !flush_i && (widx == ridx)) begin
            v = 1'b1;
            d = wdat;
        end else begin
            v = m_valid[ridx];
            d = m_data[ridx];
        end
        e.hit = v;
        e.tag = "";
        if (!v)              e.target = pc_i + 8'd1;
        else if (mode == REL) e.target = pc_i + d;
        else                 e.target = d;
        return e;
    endfunction

    task automatic applyStimulus(input logic rst_i, input logic flush_i,
                                 input logic wen, input logic [7:0] widx, input logic [7:0] wdat,
                                 input logic rreq, input logic [7:0] ridx, input mode_t mode,
                                 input logic [7:0] pc_i, input string tag);
        exp_t e;
        reset       = rst_i;
        bus.flush   = flush_i;
        bus.wr_en   = wen;
        bus.wr_idx  = widx;
        bus.wr_data = wdat;
        bus.rd_req  = rreq;
        bus.rd_idx  = ridx;
        bus.rd_mode = mode;
        bus.pc      = pc_i;
        if (!rst_i && !m_busy && rreq) begin
            e = predict(ridx, mode, pc_i, wen, widx, wdat, flush_i);
            e.tag = tag;
            sbq.push_back(e);
        end
        @(posedge clk);
        #1;
        if (rst_i) begin
            m_busy = 1'b1;
            m_cnt  = 0;
            sbq.delete();
            last_hit    = 1'b0;
            last_target = 8'h00;
        end else if (flush_i) begin
            m_busy = 1'b1;
            m_cnt  = 0;
        end else if (m_busy) begin
            if (m_cnt == 255) begin
                m_busy = 1'b0;
                for (int i = 0; i < 256; i++) begin
                    m_valid[i] = 1'b0;
                    m_data[i]  = 8'h00;
                end
            end else begin
                m_cnt++;
            end
        end else if (wen) begin
            m_data[widx]  = wdat;
            m_valid[widx] = 1'b1;
        end
        checkOutput({tag, ".busy"}, 32'(bus.busy), 32'(m_busy));
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            checkOutput({e.tag, ".rd_valid"}, 32'(bus.rd_valid), 32'd1);
            checkOutput({e.tag, ".hit"}, 32'(bus.hit), 32'(e.hit));
            checkOutput({e.tag, ".target"}, 32'(bus.target), 32'(e.target));
            last_hit    = e.hit;
            last_target = e.target;
        end else begin
            checkOutput({tag, ".rd_valid"}, 32'(bus.rd_valid), 32'd0);
            checkOutput({tag, ".hit_hold"}, 32'(bus.hit), 32'(last_hit));
            checkOutput({tag, ".target_hold"}, 32'(bus.target), 32'(last_target));
        end
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, ABS, 8'h00, tag);
        end
    endtask

    // Directed sequence, then a short random mix checked against the model.
    initial begin
        logic       r_wen, r_rreq;
        logic [7:0] r_widx, r_wdat, r_ridx, r_pc;
        mode_t      r_mode;

        $display("[TB] start");
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, ABS, 8'h00, "reset");
        idle(256, "sweep1");

        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h05, ABS, 8'h20, "miss5");
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h03, 8'h0F, 1'b0, 8'h00, ABS, 8'h00, "wr3");
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h03, ABS, 8'h20, "abs3");
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h01, 8'hFB, 1'b0, 8'h00, ABS, 8'h00, "wr1");
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h01, REL, 8'h10, "rel1");
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h01, REL, 8'h02, "rel1wrap");
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h07, 8'h44, 1'b1, 8'h07, ABS, 8'h00, "byp7");
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h09, REL, 8'hFF, "missrelwrap");
        idle(2, "gap");

        applyStimulus(1'b0, 1'b1, 1'b1, 8'h08, 8'h55, 1'b1, 8'h03, ABS, 8'h40, "flushrun");
        for (int i = 0; i < 50; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 8'(i), 8'(i * 3), 1'b1, 8'(i), ABS, 8'(i), "sweepreads");
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 8'h03, ABS, 8'h00, "flushinit");
        idle(256, "sweep2");
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h03, ABS, 8'h30, "postflush3");
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h08, ABS, 8'h10, "postflush8");

        applyStimulus(1'b0, 1'b0, 1'b1, 8'h20, 8'h99, 1'b0, 8'h00, ABS, 8'h00, "wr20");
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h20, ABS, 8'h50, "rstread");
        idle(100, "sweep100");
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, ABS, 8'h00, "rst100");
        idle(256, "sweep3");

        for (int i = 0; i < 60; i++) begin
            r_wen  = 1'($urandom_range(0, 1));
            r_widx = 8'($urandom_range(0, 15));
            r_wdat = 8'($urandom);
            r_rreq = 1'($urandom_range(0, 1));
            r_ridx = 8'($urandom_range(0, 15));
            r_mode = mode_t'($urandom_range(0, 1));
            r_pc   = 8'($urandom);
            applyStimulus(1'b0, 1'b0, r_wen, r_widx, r_wdat, r_rreq, r_ridx, r_mode, r_pc, "rand");
        end
        idle(2, "drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
